// File: rtl/iic_target_regport.sv
// rtl/iic_target_regport.sv - I2C target bridging to a 16-bit register port; `define IIC_TARGET_AUTOINC_EN for burst auto-increment
module iic_target_regport #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic        clk_8m,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic        reg_wr,
    output logic [7:0]  reg_wdata,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        err
);

    localparam int             CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REGH      = 4'd3;
    localparam logic [3:0] S_REGH_ACK  = 4'd4;
    localparam logic [3:0] S_REGL      = 4'd5;
    localparam logic [3:0] S_REGL_ACK  = 4'd6;
    localparam logic [3:0] S_WDATA     = 4'd7;
    localparam logic [3:0] S_WDATA_ACK = 4'd8;
    localparam logic [3:0] S_RDATA     = 4'd9;
    localparam logic [3:0] S_RDATA_ACK = 4'd10;

    // Index 0 carries SCL, index 1 carries SDA through the whole front end.
    logic [1:0]         meta_q, meta_d;
    logic [1:0]         sync_q, sync_d;
    logic [1:0]         filt_q, filt_d;
    logic [1:0]         filt_dly_q, filt_dly_d;
    logic [1:0][CW-1:0] fcnt_q, fcnt_d;

    logic [3:0]  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  regh_q, regh_d;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [1:0]  rd_pipe_q, rd_pipe_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        reg_wr_q, reg_wr_d;
    logic        reg_rd_q, reg_rd_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic scl_f, sda_f;
    logic scl_rise, scl_fall;
    logic start_det, stop_det;
    logic in_byte, mid_byte;

    always_comb begin
        meta_d     = {sda_i, scl_i};
        sync_d     = meta_q;
        filt_dly_d = filt_q;
        filt_d     = filt_q;
        fcnt_d     = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == CNT_MAX) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = filt_q[0] & ~filt_dly_q[0];
    assign scl_fall  = ~filt_q[0] & filt_dly_q[0];
    assign start_det = ~filt_q[1] & filt_dly_q[1] & scl_f;
    assign stop_det  = filt_q[1] & ~filt_dly_q[1] & scl_f;

    assign in_byte = (state_q == S_ADDR) || (state_q == S_REGH) || (state_q == S_REGL) ||
                     (state_q == S_WDATA) || (state_q == S_RDATA);
    // The SCL rise that carries a START/STOP has already bumped the count, so a
    // count of 1 is a clean boundary and 2..8 means at least one bit was completed.
    assign mid_byte = in_byte && (bit_cnt_q >= 4'd2);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        regh_d      = regh_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        rd_pipe_d   = {rd_pipe_q[0], reg_rd_q};
        rbuf_d      = rd_pipe_q[1] ? reg_rdata : rbuf_q;
`ifdef IIC_TARGET_AUTOINC_EN
        if (reg_wr_q) begin
            reg_addr_d = reg_addr_q + 16'd1;
        end
`endif
        if (start_det || stop_det) begin
            err_d     = mid_byte;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            if (start_det) begin
                state_d = S_ADDR;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_ADDR, S_REGH, S_REGL, S_WDATA: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            S_ADDR: begin
                                if (shift_q[7:1] == DEV_ADDR) begin
                                    state_d  = S_ADDR_ACK;
                                    sda_oe_d = 1'b1;
                                    busy_d   = 1'b1;
                                    rw_d     = shift_q[0];
                                    reg_rd_d = shift_q[0];
                                end else begin
                                    state_d = S_IDLE;
                                    busy_d  = 1'b0;
                                end
                            end
                            S_REGH: begin
                                regh_d   = shift_q;
                                state_d  = S_REGH_ACK;
                                sda_oe_d = 1'b1;
                            end
                            S_REGL: begin
                                state_d  = S_REGL_ACK;
                                sda_oe_d = 1'b1;
                            end
                            S_WDATA: begin
                                reg_wdata_d = shift_q;
                                reg_wr_d    = 1'b1;
                                state_d     = S_WDATA_ACK;
                                sda_oe_d    = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = S_RDATA;
                            shift_d  = rbuf_q;
                            sda_oe_d = ~rbuf_q[7];
                        end else begin
                            state_d  = S_REGH;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_REGH_ACK: begin
                    if (scl_fall) begin
                        state_d  = S_REGL;
                        sda_oe_d = 1'b0;
                    end
                end
                S_REGL_ACK: begin
                    if (scl_fall) begin
                        reg_addr_d = {regh_q, shift_q};
                        state_d    = S_WDATA;
                        sda_oe_d   = 1'b0;
                    end
                end
                S_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = S_WDATA;
                        sda_oe_d = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (scl_rise && (bit_cnt_q != 4'd8)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        state_d   = S_RDATA_ACK;
                        sda_oe_d  = 1'b0;
                    end else if (scl_fall && (bit_cnt_q != 4'd0)) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                S_RDATA_ACK: begin
                    // Fetch the next byte at the ACK sample so it is latched before SCL falls.
                    if (scl_rise) begin
                        mack_d = ~sda_f;
                        if (!sda_f) begin
                            reg_rd_d = 1'b1;
`ifdef IIC_TARGET_AUTOINC_EN
                            reg_addr_d = reg_addr_q + 16'd1;
`endif
                        end
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            state_d  = S_RDATA;
                            shift_d  = rbuf_q;
                            sda_oe_d = ~rbuf_q[7];
                        end else begin
                            state_d  = S_IDLE;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= 2'b11;
            sync_q      <= 2'b11;
            filt_q      <= 2'b11;
            filt_dly_q  <= 2'b11;
            fcnt_q      <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            regh_q      <= 8'd0;
            rbuf_q      <= 8'd0;
            rd_pipe_q   <= 2'd0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 16'd0;
            reg_wdata_q <= 8'd0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_dly_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            regh_q      <= regh_d;
            rbuf_q      <= rbuf_d;
            rd_pipe_q   <= rd_pipe_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_iic_target_regport.sv
// tb/tb_iic_target_regport.sv - directed vector bench for iic_target_regport
`timescale 1ns/1ps
module tb_iic_target_regport;

    localparam int Q = 10;
`ifdef IIC_TARGET_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic        clk_8m = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        scl_glitch = 1'b0;
    logic        scl_i, sda_i, sda_oe, reg_wr, reg_rd, busy, err;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = 8'h00;

    assign scl_i = scl_m & ~scl_glitch;
    assign sda_i = sda_m & ~sda_oe;

    always #5 clk_8m = ~clk_8m;

    iic_target_regport dut (
        .clk_8m    (clk_8m),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err       (err)
    );

    // Bus-side monitor and register-file responder.
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          err_cnt = 0;
    int          oe_cnt = 0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [7:0]  last_wdata = 8'h0;
    logic [15:0] rd_addr [8];
    logic [7:0]  rq [8];

    always @(negedge clk_8m) begin
        if (reg_wr) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = reg_addr;
            last_wdata   = reg_wdata;
        end
        if (reg_rd) begin
            if (rd_cnt < 8) begin
                rd_addr[rd_cnt] = reg_addr;
                reg_rdata       = rq[rd_cnt];
            end
            rd_cnt = rd_cnt + 1;
        end
        if (err) err_cnt = err_cnt + 1;
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_8m);
        #1;
    endtask

    task automatic bit_wr(input logic b, input logic g, output logic seen);
        tick(Q);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        if (g) begin
            scl_glitch = 1'b1;
            tick(2);
            scl_glitch = 1'b0;
            tick(2);
        end
        seen = sda_i;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_wr(b[i], (i == gbit), s);
        bit_wr(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        logic [7:0] t;
        for (int i = 7; i >= 0; i--) begin
            bit_wr(1'b1, 1'b0, s);
            t[i] = s;
        end
        bit_wr(~mack, 1'b0, s);
        b = t;
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop_c();
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  rh;
        logic [7:0]  rl;
        logic [7:0]  d;
        int          nd;
        logic        exp_ack;
        int          exp_wr;
        logic [15:0] exp_wr_addr;
        logic [7:0]  exp_wdata;
        logic [15:0] exp_final;
    } wvec_t;

    wvec_t tv [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        ack, a1, ack_all;
        logic [7:0]  b0, b1;
        int          wr0, err0, oe0, rd0;

        tv[0] = '{"w1234", 8'hA0, 8'h12, 8'h34, 8'h5A, 1, 1'b1, 1, 16'h1234, 8'h5A, AI ? 16'h1235 : 16'h1234};
        tv[1] = '{"wrap",  8'hA0, 8'hFF, 8'hFF, 8'hA5, 2, 1'b1, 2, AI ? 16'h0000 : 16'hFFFF, 8'hA5, AI ? 16'h0001 : 16'hFFFF};
        tv[2] = '{"nomatch", 8'hB0, 8'h00, 8'h00, 8'h00, 0, 1'b0, 0, 16'h0000, 8'h00, AI ? 16'h0001 : 16'hFFFF};
        tv[3] = '{"hdronly", 8'hA0, 8'h00, 8'h10, 8'h00, 0, 1'b1, 0, 16'h0000, 8'h00, 16'h0010};
        tv[4] = '{"wC300", 8'hA0, 8'hC3, 8'h00, 8'hFF, 1, 1'b1, 1, 16'hC300, 8'hFF, AI ? 16'hC301 : 16'hC300};
        rq[0] = 8'h3C;
        rq[1] = 8'hC3;
        rq[2] = 8'h00;
        for (int i = 3; i < 8; i++) rq[i] = 8'hEE;

        tick(3);
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_reg_wr", 32'(reg_wr), 32'h0);
        check("rst_reg_rd", 32'(reg_rd), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_reg_addr", 32'(reg_addr), 32'h0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        rst_n = 1'b1;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            wr0 = wr_cnt; err0 = err_cnt; oe0 = oe_cnt;
            start_c();
            send_byte(tv[v].a, -1, ack);
            ack_all = ack;
            if (ack) begin
                send_byte(tv[v].rh, -1, a1); ack_all = ack_all & a1;
                send_byte(tv[v].rl, -1, a1); ack_all = ack_all & a1;
                for (int k = 0; k < tv[v].nd; k++) begin
                    send_byte(tv[v].d, -1, a1);
                    ack_all = ack_all & a1;
                end
            end
            stop_c();
            tick(4);
            check({tv[v].name, "_ack"}, 32'(ack_all), 32'(tv[v].exp_ack));
            check({tv[v].name, "_oe_seen"}, 32'(oe_cnt != oe0), 32'(tv[v].exp_ack));
            check({tv[v].name, "_wr_cnt"}, 32'(wr_cnt - wr0), 32'(tv[v].exp_wr));
            if (tv[v].exp_wr > 0) begin
                check({tv[v].name, "_wr_addr"}, 32'(last_wr_addr), 32'(tv[v].exp_wr_addr));
                check({tv[v].name, "_wdata"}, 32'(last_wdata), 32'(tv[v].exp_wdata));
            end
            check({tv[v].name, "_final_addr"}, 32'(reg_addr), 32'(tv[v].exp_final));
            check({tv[v].name, "_busy"}, 32'(busy), 32'h0);
            check({tv[v].name, "_err"}, 32'(err_cnt - err0), 32'h0);
        end

        // Register-address header, repeated START, two-byte read.
        rd0 = rd_cnt; err0 = err_cnt;
        start_c();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h00, -1, a1); ack = ack & a1;
        send_byte(8'h10, -1, a1); ack = ack & a1;
        start_c();
        send_byte(8'hA1, -1, a1); ack = ack & a1;
        check("rd_hdr_ack", 32'(ack), 32'h1);
        check("rd_busy_mid", 32'(busy), 32'h1);
        recv_byte(1'b1, b0);
        recv_byte(1'b0, b1);
        tick(Q);
        check("rd_busy_nack", 32'(busy), 32'h0);
        stop_c();
        tick(4);
        check("rd_byte0", 32'(b0), 32'h3C);
        check("rd_byte1", 32'(b1), 32'hC3);
        check("rd_count", 32'(rd_cnt - rd0), 32'd2);
        check("rd_addr0", 32'(rd_addr[rd0]), 32'h0010);
        check("rd_addr1", 32'(rd_addr[rd0 + 1]), AI ? 32'h0011 : 32'h0010);
        check("rd_err", 32'(err_cnt - err0), 32'h0);

        // STOP after four bits of a data byte.
        wr0 = wr_cnt; err0 = err_cnt;
        start_c();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h12, -1, a1); ack = ack & a1;
        send_byte(8'h34, -1, a1); ack = ack & a1;
        for (int i = 7; i >= 4; i--) bit_wr(b0[i], 1'b0, a1);
        stop_c();
        tick(4);
        check("abort_hdr_ack", 32'(ack), 32'h1);
        check("abort_err", 32'(err_cnt - err0), 32'd1);
        check("abort_wr", 32'(wr_cnt - wr0), 32'd0);
        check("abort_busy", 32'(busy), 32'h0);
        send_byte(8'hA0, -1, ack);
        check("abort_idle_noack", 32'(ack), 32'h0);
        stop_c();
        tick(4);
        check("abort_err_total", 32'(err_cnt - err0), 32'd1);

        // Two-cycle SCL glitch while SCL is high in a data bit.
        wr0 = wr_cnt; err0 = err_cnt;
        start_c();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h12, -1, a1); ack = ack & a1;
        send_byte(8'h34, -1, a1); ack = ack & a1;
        send_byte(8'h5A, 4, a1); ack = ack & a1;
        stop_c();
        tick(4);
        check("glitch_ack", 32'(ack), 32'h1);
        check("glitch_wr", 32'(wr_cnt - wr0), 32'd1);
        check("glitch_wdata", 32'(last_wdata), 32'h5A);
        check("glitch_err", 32'(err_cnt - err0), 32'h0);

        // Reset asserted while the target is driving a read bit low.
        start_c();
        send_byte(8'hA1, -1, ack);
        check("rstrd_ack", 32'(ack), 32'h1);
        tick(Q);
        check("rstrd_oe_pre", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstrd_oe_async", 32'(sda_oe), 32'h0);
        check("rstrd_busy", 32'(busy), 32'h0);
        check("rstrd_addr", 32'(reg_addr), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        wr0 = wr_cnt; err0 = err_cnt;
        start_c();
        send_byte(8'hA0, -1, ack);
        check("post_rst_ack", 32'(ack), 32'h1);
        send_byte(8'h12, -1, a1);
        send_byte(8'h34, -1, a1);
        send_byte(8'h5A, -1, a1);
        stop_c();
        tick(4);
        check("post_rst_wr", 32'(wr_cnt - wr0), 32'd1);
        check("post_rst_addr", 32'(last_wr_addr), 32'h1234);
        check("post_rst_wdata", 32'(last_wdata), 32'h5A);
        check("post_rst_err", 32'(err_cnt - err0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
